// File: rtl/counter_3ch_pkg.sv
// Shared constants for the three-channel down-counter peripheral: bus select codes,
// control-word field offsets and channel mode encodings.
package counter_3ch_pkg;

    localparam int NUM_CH = 3;

    localparam logic [1:0] SEL_CH0  = 2'b00;
    localparam logic [1:0] SEL_CH1  = 2'b01;
    localparam logic [1:0] SEL_CH2  = 2'b10;
    localparam logic [1:0] SEL_CTRL = 2'b11;

    localparam int CTRL_EN           = 0;
    localparam int CTRL_MODE         = 1;
    localparam int CTRL_CH_STRIDE    = 4;
    localparam int CTRL_PRESCALE_LSB = 12;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_3ch_if.sv
// Bus-decoder side of the counter peripheral: write strobe/select/data in,
// read data and the three channel output levels out.
interface counter_3ch_if #(parameter int WIDTH = 32);

    logic             counter_we;
    logic [1:0]       counter_set;
    logic [WIDTH-1:0] Peripheral_in;
    logic [WIDTH-1:0] counter_out;
    logic             counter0_out;
    logic             counter1_out;
    logic             counter2_out;

    modport master (
        output counter_we, counter_set, Peripheral_in,
        input  counter_out, counter0_out, counter1_out, counter2_out
    );

    modport slave (
        input  counter_we, counter_set, Peripheral_in,
        output counter_out, counter0_out, counter1_out, counter2_out
    );

endinterface

// File: rtl/counter_3ch_chan.sv
// One down-counter channel: count/reload registers and output level, with
// load-over-tick priority and one-shot / periodic terminal behaviour.
module counter_3ch_chan
    import counter_3ch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             tick_i,
    input  logic             en_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] count_o,
    output logic             out_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             out_q, out_d;

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        out_d    = out_q;
        if (load_i) begin
            reload_d = din_i;
            count_d  = din_i;
            out_d    = 1'b0;
        end else if (tick_i && en_i && (count_q != '0)) begin
            if (count_q != WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else if (mode_i == MODE_PERIODIC) begin
                // count==1 implies reload>=1, so the wave never stalls here
                count_d = reload_q;
                out_d   = ~out_q;
            end else begin
                count_d = '0;
                out_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            reload_q <= '0;
            out_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            out_q    <= out_d;
        end
    end

    assign count_o = count_q;
    assign out_o   = out_q;

endmodule

// File: rtl/counter_3ch.sv
// Three-channel timer top: control register, shared tick source, write decode and read mux.
// COUNTER_PRESCALE_EN adds a divisor field in ctrl[12 +: PRESCALE_W] gating the tick.
module counter_3ch
    import counter_3ch_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    counter_3ch_if.slave  bus
);

`ifdef COUNTER_PRESCALE_EN
    localparam bit PRESCALE_EN = 1'b1;
`else
    localparam bit PRESCALE_EN = 1'b0;
`endif

    localparam logic [WIDTH-1:0] CH_FIELD    = WIDTH'(12'h333);
    localparam logic [WIDTH-1:0] PRESC_FIELD =
        WIDTH'(((64'd1 << PRESCALE_W) - 64'd1) << CTRL_PRESCALE_LSB);
    localparam logic [WIDTH-1:0] CTRL_WMASK  =
        CH_FIELD | (PRESCALE_EN ? PRESC_FIELD : '0);

    logic [WIDTH-1:0] ctrl_q, ctrl_d;
    logic             ctrl_we;
    logic             tick;

    logic [NUM_CH-1:0][WIDTH-1:0] count;
    logic [NUM_CH-1:0]            chan_out;

    assign ctrl_we = bus.counter_we && (bus.counter_set == SEL_CTRL);

    always_comb begin
        ctrl_d = ctrl_q;
        if (ctrl_we) ctrl_d = bus.Peripheral_in & CTRL_WMASK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ctrl_q <= '0;
        else     ctrl_q <= ctrl_d;
    end

`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PRESCALE_W-1:0] divisor;

    assign divisor = ctrl_q[CTRL_PRESCALE_LSB +: PRESCALE_W];
    assign tick    = (presc_q == divisor);

    // a control write restarts the divide phase so a new divisor takes effect cleanly
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (ctrl_we) presc_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) presc_q <= '0;
        else     presc_q <= presc_d;
    end
`else
    assign tick = 1'b1;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        counter_3ch_chan #(.WIDTH(WIDTH)) u_chan (
            .clk     (clk),
            .rst     (rst),
            .load_i  (bus.counter_we && (bus.counter_set == 2'(g))),
            .din_i   (bus.Peripheral_in),
            .tick_i  (tick),
            .en_i    (ctrl_q[g*CTRL_CH_STRIDE + CTRL_EN]),
            .mode_i  (ctrl_q[g*CTRL_CH_STRIDE + CTRL_MODE]),
            .count_o (count[g]),
            .out_o   (chan_out[g])
        );
    end

    always_comb begin
        case (bus.counter_set)
            SEL_CH0: bus.counter_out = count[0];
            SEL_CH1: bus.counter_out = count[1];
            SEL_CH2: bus.counter_out = count[2];
            default: bus.counter_out = ctrl_q;
        endcase
    end

    assign bus.counter0_out = chan_out[0];
    assign bus.counter1_out = chan_out[1];
    assign bus.counter2_out = chan_out[2];

endmodule

// File: tb/tb_counter_3ch.sv
// Randomised + directed bench for counter_3ch against a behavioural timer model.
// Honours COUNTER_PRESCALE_EN the same way the design does.
module tb_counter_3ch;
    import counter_3ch_pkg::*;

`ifdef COUNTER_PRESCALE_EN
    localparam logic [31:0] WMASK = 32'h0FFF_F333;
`else
    localparam logic [31:0] WMASK = 32'h0000_0333;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    counter_3ch_if #(.WIDTH(32)) bus ();

    counter_3ch #(.WIDTH(32), .PRESCALE_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // behavioural model: timer state as plain integers
    int unsigned m_cnt[3];
    int unsigned m_rel[3];
    bit          m_out[3];
    logic [31:0] m_ctrl;
    int unsigned m_presc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 3; n++) begin
                m_cnt[n] = 0; m_rel[n] = 0; m_out[n] = 0;
            end
            m_ctrl  = 0;
            m_presc = 0;
        end else begin
            bit          tk;
            bit          we;
            int unsigned sel;
            logic [31:0] din;
            we  = bus.counter_we;
            sel = bus.counter_set;
            din = bus.Peripheral_in;
`ifdef COUNTER_PRESCALE_EN
            tk = (m_presc == m_ctrl[27:12]);
            if (we && sel == 3)  m_presc = 0;
            else if (tk)         m_presc = 0;
            else                 m_presc = m_presc + 1;
`else
            tk = 1'b1;
`endif
            for (int n = 0; n < 3; n++) begin
                bit en, md;
                en = m_ctrl[4*n];
                md = m_ctrl[4*n+1];
                if (we && sel == n) begin
                    m_cnt[n] = din; m_rel[n] = din; m_out[n] = 0;
                end else if (tk && en && m_cnt[n] > 0) begin
                    if (m_cnt[n] > 1) m_cnt[n] = m_cnt[n] - 1;
                    else if (md == MODE_ONESHOT) begin m_cnt[n] = 0; m_out[n] = 1; end
                    else begin m_cnt[n] = m_rel[n]; m_out[n] = !m_out[n]; end
                end
            end
            if (we && sel == 3) m_ctrl = din & WMASK;
        end
    end

    // compare process: every cycle out of reset, read data for the current select and levels
    always @(negedge clk) begin
        if (!rst) begin
            logic [34:0] exp_v, got_v;
            int unsigned s;
            s = bus.counter_set;
            exp_v = {(s < 3) ? 32'(m_cnt[s]) : m_ctrl, m_out[2], m_out[1], m_out[0]};
            got_v = {bus.counter_out, bus.counter2_out, bus.counter1_out, bus.counter0_out};
            n_chk++;
            if (got_v !== exp_v)
                $display("FAIL model t=%0t sel=%0d got=%h exp=%h", $time, s, got_v, exp_v);
            else
                n_pass++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", name, got, exp);
        else n_pass++;
    endtask

    task automatic cyc(input bit we, input logic [1:0] sel, input logic [31:0] d);
        bus.counter_we = we; bus.counter_set = sel; bus.Peripheral_in = d;
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [1:0] sel);
        bus.counter_we = 1'b0; bus.counter_set = sel; #1;
    endtask

    function automatic logic [31:0] outs();
        return {29'd0, bus.counter2_out, bus.counter1_out, bus.counter0_out};
    endfunction

    initial begin
        int unsigned seq1[6];
        bit          out1[6];
        seq1 = '{2, 1, 3, 2, 1, 3};
        out1 = '{0, 0, 1, 1, 1, 0};
        bus.counter_we = 0; bus.counter_set = 0; bus.Peripheral_in = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_read", bus.counter_out, 32'd0);
        chk("reset_outs", outs(), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // one-shot on channel 0
        cyc(1, SEL_CH0, 5);
        cyc(1, SEL_CTRL, 32'h001);
        rd(SEL_CH0);
        chk("os_start", bus.counter_out, 5);
        for (int k = 4; k >= 0; k--) begin
            cyc(0, SEL_CH0, 0);
            chk($sformatf("os_cnt%0d", k), bus.counter_out, k);
            chk($sformatf("os_out%0d", k), outs() & 1, (k == 0) ? 1 : 0);
        end
        repeat (3) cyc(0, SEL_CH0, 0);
        chk("os_hold", outs() & 1, 1);
        cyc(1, SEL_CH0, 3);
        chk("os_reload_out", outs() & 1, 0);
        chk("os_reload_cnt", bus.counter_out, 3);

        // periodic on channel 1
        cyc(1, SEL_CH1, 3);
        cyc(1, SEL_CTRL, 32'h030);
        rd(SEL_CH1);
        chk("per_start", bus.counter_out, 3);
        for (int k = 0; k < 6; k++) begin
            cyc(0, SEL_CH1, 0);
            chk($sformatf("per_cnt%0d", k), bus.counter_out, seq1[k]);
            chk($sformatf("per_out%0d", k), (outs() >> 1) & 1, 32'(out1[k]));
        end

        // collision and enable hold on channel 2
        cyc(1, SEL_CH2, 4);
        cyc(1, SEL_CTRL, 32'h300);
        repeat (3) cyc(0, SEL_CH2, 0);
        chk("col_pre", bus.counter_out, 1);
        cyc(1, SEL_CH2, 10);
        chk("col_cnt", bus.counter_out, 10);
        chk("col_out", (outs() >> 2) & 1, 0);
        cyc(1, SEL_CTRL, 32'h000);
        rd(SEL_CH2);
        repeat (20) cyc(0, SEL_CH2, 0);
        chk("hold_cnt", bus.counter_out, 9);
        cyc(1, SEL_CTRL, 32'h300);
        rd(SEL_CH2);
        chk("resume0", bus.counter_out, 9);
        cyc(0, SEL_CH2, 0);
        chk("resume1", bus.counter_out, 8);

        // async reset mid-count
        #1 rst = 1'b1; #1;
        chk("midrst_read", bus.counter_out, 0);
        chk("midrst_outs", outs(), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // control readback
        cyc(1, SEL_CTRL, 32'hFFFF_FFFF);
        rd(SEL_CTRL);
        chk("ctrl_readback", bus.counter_out, WMASK);

`ifdef COUNTER_PRESCALE_EN
        cyc(1, SEL_CTRL, 0);
        cyc(1, SEL_CH0, 4);
        cyc(1, SEL_CTRL, 32'h3001);
        rd(SEL_CH0);
        repeat (4) cyc(0, SEL_CH0, 0);
        chk("psc_4", bus.counter_out, 3);
        repeat (11) cyc(0, SEL_CH0, 0);
        chk("psc_15_cnt", bus.counter_out, 1);
        chk("psc_15_out", outs() & 1, 0);
        cyc(0, SEL_CH0, 0);
        chk("psc_16_cnt", bus.counter_out, 0);
        chk("psc_16_out", outs() & 1, 1);
`endif

        // random traffic with occasional async reset pulses
        for (int i = 0; i < 3000; i++) begin
            logic [1:0]  s;
            logic [31:0] d;
            bit          we;
            s  = 2'($urandom_range(0, 3));
            we = ($urandom_range(0, 5) == 0);
            if (s == SEL_CTRL)
                d = ($urandom & 32'hF000_0FFF) | (32'($urandom_range(0, 3)) << 12);
            else
                d = 32'($urandom_range(0, 9));
            cyc(we, s, d);
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b1; #1;
                chk("rnd_rst_outs", outs(), 0);
                #1 rst = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
